// File: rtl/ahb_addr_decoder.sv
// AHB-Lite address decoder: one-hot address-phase selects, registered data-phase
// mux index, and a built-in default slave that answers unmapped transfers with ERROR.
module ahb_addr_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int HSLV_NUM   = 5,
    parameter int SLV_CNT    = 4,
    parameter int DEF_SLV    = 31,
    parameter logic [SLV_CNT*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [SLV_CNT*ADDR_WIDTH-1:0] SLV_MASK = {4{32'hF000_0000}}
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    output logic [SLV_CNT-1:0]    hsel_oh,
    output logic [HSLV_NUM-1:0]   hsel_dp,
    output logic                  def_hready,
    output logic                  def_hresp,
    output logic                  def_hexokay,
    output logic [31:0]           def_hrdata,
    output logic [7:0]            err_cnt,
    output logic [1:0]            dbg_state
);

    localparam logic [HSLV_NUM-1:0] DEF_IDX = HSLV_NUM'(DEF_SLV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } def_state_e;

    def_state_e            state_q;
    logic [HSLV_NUM-1:0]   hsel_dp_q;
    logic [HSLV_NUM-1:0]   hsel_dp_d;
    logic                  def_hready_q;
    logic                  def_hresp_q;
    logic [7:0]            err_cnt_q;
    logic [7:0]            err_cnt_d;

    logic                  hit;
    logic [HSLV_NUM-1:0]   addr_idx;
    logic [SLV_CNT-1:0]    oh;
    logic                  err_start;
    logic                  unused_htrans;

    // Scan from the top index down so the lowest matching slave overrides the rest.
    always_comb begin
        hit      = 1'b0;
        addr_idx = DEF_IDX;
        oh       = '0;
        for (int i = SLV_CNT - 1; i >= 0; i--) begin
            if ((haddr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit      = 1'b1;
                addr_idx = HSLV_NUM'(i);
                oh       = '0;
                oh[i]    = 1'b1;
            end
        end
    end

    // Only NONSEQ/SEQ (htrans[1]) to an unmapped address earns an ERROR.
    assign err_start     = hready & htrans[1] & ~hit;
    assign unused_htrans = htrans[0];

    assign hsel_dp_d = hready ? addr_idx : hsel_dp_q;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q      <= ST_IDLE;
            hsel_dp_q    <= DEF_IDX;
            def_hready_q <= 1'b1;
            def_hresp_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            hsel_dp_q <= hsel_dp_d;
            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (err_start) begin
                        state_q      <= ST_ERR1;
                        def_hready_q <= 1'b0;
                        def_hresp_q  <= 1'b1;
                        err_cnt_q    <= err_cnt_d;
                    end else begin
                        state_q      <= ST_IDLE;
                        def_hready_q <= 1'b1;
                        def_hresp_q  <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state_q      <= ST_ERR2;
                    def_hready_q <= 1'b1;
                    def_hresp_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    def_hready_q <= 1'b1;
                    def_hresp_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hsel_oh     = oh;
    assign hsel_dp     = hsel_dp_q;
    assign def_hready  = def_hready_q;
    assign def_hresp   = def_hresp_q;
    assign def_hexokay = 1'b0;
    assign def_hrdata  = 32'd0;
    assign err_cnt     = err_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Directed bench for ahb_addr_decoder: decode, data-phase index, default-slave
// ERROR sequencing, error counter saturation and reset behaviour.
module tb_ahb_addr_decoder;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic [3:0]  hsel_oh;
  logic [4:0]  hsel_dp;
  logic        def_hready;
  logic        def_hresp;
  logic        def_hexokay;
  logic [31:0] def_hrdata;
  logic [7:0]  err_cnt;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ERR1 = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  ahb_addr_decoder dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .haddr       (haddr),
    .htrans      (htrans),
    .hready      (hready),
    .hsel_oh     (hsel_oh),
    .hsel_dp     (hsel_dp),
    .def_hready  (def_hready),
    .def_hresp   (def_hresp),
    .def_hexokay (def_hexokay),
    .def_hrdata  (def_hrdata),
    .err_cnt     (err_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
    haddr  = a;
    htrans = t;
    hready = r;
  endtask

  task automatic check_def(input string tag, input logic [1:0] st, input logic rdy,
                           input logic rsp, input logic [7:0] cnt);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(st));
    check_eq({tag, "_hready"}, 32'(def_hready), 32'(rdy));
    check_eq({tag, "_hresp"}, 32'(def_hresp), 32'(rsp));
    check_eq({tag, "_errcnt"}, 32'(err_cnt), 32'(cnt));
  endtask

  logic [31:0] dec_addr [5];
  logic [3:0]  dec_oh   [5];

  initial begin
    checks   = 0;
    failures = 0;
    dec_addr[0] = 32'h0000_0000; dec_oh[0] = 4'b0001;
    dec_addr[1] = 32'h1FFF_FFFC; dec_oh[1] = 4'b0010;
    dec_addr[2] = 32'h2000_0010; dec_oh[2] = 4'b0100;
    dec_addr[3] = 32'h3ABC_0000; dec_oh[3] = 4'b1000;
    dec_addr[4] = 32'h8000_0000; dec_oh[4] = 4'b0000;

    // reset values
    hreset = 1'b1;
    drive(32'h1000_0004, 2'd0, 1'b1);
    cyc();
    cyc();
    check_eq("rst_hsel_oh", 32'(hsel_oh), 32'h2);
    check_eq("rst_hsel_dp", 32'(hsel_dp), 32'd31);
    check_def("rst", S_IDLE, 1'b1, 1'b0, 8'd0);
    check_eq("rst_hexokay", 32'(def_hexokay), 32'd0);
    check_eq("rst_hrdata", def_hrdata, 32'd0);
    #3 hreset = 1'b0;

    // combinational decode table
    for (int i = 0; i < 5; i++) begin
      drive(dec_addr[i], 2'd0, 1'b1);
      #1;
      check_eq($sformatf("dec_oh_%0d", i), 32'(hsel_oh), 32'(dec_oh[i]));
    end
    cyc();

    // mapped decode then wait states; unmapped NONSEQ with hready=0 is ignored
    drive(32'h2000_0010, 2'd2, 1'b1);
    #1;
    check_eq("map_hsel_oh", 32'(hsel_oh), 32'h4);
    cyc();
    check_eq("map_hsel_dp", 32'(hsel_dp), 32'd2);
    drive(32'h5000_0000, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq($sformatf("wait_hsel_dp_%0d", i), 32'(hsel_dp), 32'd2);
      check_def("wait", S_IDLE, 1'b1, 1'b0, 8'd0);
    end

    // single error
    drive(32'h5000_0000, 2'd2, 1'b1);
    cyc();
    check_def("e1_err1", S_ERR1, 1'b0, 1'b1, 8'd1);
    check_eq("e1_hsel_dp", 32'(hsel_dp), 32'd31);
    drive(32'h5000_0000, 2'd0, 1'b0);
    cyc();
    check_def("e1_err2", S_ERR2, 1'b1, 1'b1, 8'd1);
    check_eq("e1_hsel_dp_hold", 32'(hsel_dp), 32'd31);
    drive(32'h5000_0000, 2'd0, 1'b1);
    cyc();
    check_def("e1_idle", S_IDLE, 1'b1, 1'b0, 8'd1);

    // back-to-back unmapped
    drive(32'h6000_0000, 2'd2, 1'b1);
    cyc();
    check_def("b2b_err1a", S_ERR1, 1'b0, 1'b1, 8'd2);
    hready = 1'b0;
    cyc();
    check_def("b2b_err2a", S_ERR2, 1'b1, 1'b1, 8'd2);
    drive(32'h7000_0004, 2'd3, 1'b1);
    cyc();
    check_def("b2b_err1b", S_ERR1, 1'b0, 1'b1, 8'd3);
    hready = 1'b0;
    cyc();
    check_def("b2b_err2b", S_ERR2, 1'b1, 1'b1, 8'd3);
    drive(32'h7000_0004, 2'd0, 1'b1);
    cyc();
    check_def("b2b_idle", S_IDLE, 1'b1, 1'b0, 8'd3);

    // unmapped followed by mapped slave 0 in the ERR2 cycle
    drive(32'h9000_0000, 2'd2, 1'b1);
    cyc();
    check_def("um_err1", S_ERR1, 1'b0, 1'b1, 8'd4);
    hready = 1'b0;
    cyc();
    check_def("um_err2", S_ERR2, 1'b1, 1'b1, 8'd4);
    drive(32'h0000_0000, 2'd2, 1'b1);
    cyc();
    check_def("um_idle", S_IDLE, 1'b1, 1'b0, 8'd4);
    check_eq("um_hsel_dp", 32'(hsel_dp), 32'd0);

    // benign IDLE / BUSY to unmapped
    drive(32'h8000_0000, 2'd0, 1'b1);
    cyc();
    check_def("benign_idle", S_IDLE, 1'b1, 1'b0, 8'd4);
    check_eq("benign_hsel_dp", 32'(hsel_dp), 32'd31);
    drive(32'h8000_0000, 2'd1, 1'b1);
    cyc();
    check_def("benign_busy", S_IDLE, 1'b1, 1'b0, 8'd4);

    // reset in the middle of an ERROR response
    drive(32'h5000_0000, 2'd2, 1'b1);
    cyc();
    check_def("pre_rst_err1", S_ERR1, 1'b0, 1'b1, 8'd5);
    drive(32'h5000_0000, 2'd0, 1'b0);
    #2 hreset = 1'b1;
    #1;
    check_def("mid_rst", S_IDLE, 1'b1, 1'b0, 8'd0);
    check_eq("mid_rst_hsel_dp", 32'(hsel_dp), 32'd31);
    hready = 1'b1;
    cyc();
    check_def("mid_rst_held", S_IDLE, 1'b1, 1'b0, 8'd0);
    #2 hreset = 1'b0;
    drive(32'h5000_0000, 2'd2, 1'b1);
    cyc();
    check_def("post_rst_err1", S_ERR1, 1'b0, 1'b1, 8'd1);
    drive(32'h5000_0000, 2'd0, 1'b0);
    cyc();
    check_def("post_rst_err2", S_ERR2, 1'b1, 1'b1, 8'd1);
    hready = 1'b1;
    cyc();
    check_def("post_rst_idle", S_IDLE, 1'b1, 1'b0, 8'd1);

    // saturation: 300 more unmapped NONSEQs, back to back
    for (int i = 0; i < 300; i++) begin
      drive(32'hC000_0000 + 32'(i), 2'd2, 1'b1);
      cyc();
      if (i == 253) check_eq("sat_254", 32'(err_cnt), 32'd255);
      hready = 1'b0;
      cyc();
    end
    check_eq("sat_final", 32'(err_cnt), 32'd255);
    drive(32'hC000_0000, 2'd0, 1'b1);
    cyc();
    check_def("sat_idle", S_IDLE, 1'b1, 1'b0, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
